winograd_tile_sequencer: RTL and testbench

Sequences 4x4 input tiles from the tile buffer through the 2-stage Winograd input-transform datapath (B^T·d·B) and delivers transformed tiles downstream over a ready/valid stream. The transform has no enable or stall, so this block tracks in-flight tiles and issues buffer reads only when a result slot is guaranteed. It sits between the tile buffer and the element-wise multiply stage. It walks a runtime-configured tile grid in raster order.

---
 rtl/winograd_pkg.sv | 19 +
 rtl/tile_fifo.sv | 69 ++++++
 rtl/winograd_tile_sequencer.sv | 204 ++++++++++++++++++++
 tb/tb_winograd_tile_sequencer.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/winograd_pkg.sv
// Shared definitions for the Winograd input-transform tile path.
//   W          element width in bits
//   TILE_ELEMS elements per 4x4 tile
//   TILE_BITS  packed tile width; element (r,c) sits at bits [(r*4+c)*W +: W]
//   state_e    sequencer FSM states
package winograd_pkg;

  parameter int unsigned W = 8;
  localparam int unsigned TILE_ELEMS = 16;
  localparam int unsigned TILE_BITS = W * TILE_ELEMS;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDrain,
    StDone
  } state_e;

endpackage

// File: rtl/tile_fifo.sv
// Synchronous first-word-fall-through FIFO with occupancy count.
// The head entry is visible on pop_data whenever empty is low.
//   clk, rstn   clock, asynchronous active-low reset
//   push        write push_data (ignored when full and not popping)
//   push_data   entry to write
//   pop         consume the head entry (ignored when empty)
//   pop_data    head entry (undefined while empty)
//   empty, full occupancy flags
//   count       number of stored entries, 0..DEPTH
// DEPTH must be a power of two so the pointers wrap naturally.
module tile_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             empty,
  output logic             full,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_ok, pop_ok;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CNT_W'(DEPTH));
  assign count   = count_q;
  assign pop_ok  = pop && !empty;
  // A write into a full FIFO is allowed when the head leaves in the same cycle.
  assign push_ok = push && (!full || pop_ok);
  assign pop_data = mem_q[rd_ptr_q];

  always_comb begin
    count_d = count_q;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data;
  end

  assert property (@(posedge clk) disable iff (!rstn) !(push && full && !pop));
  assert property (@(posedge clk) disable iff (!rstn) !(pop && empty));

endmodule

// File: rtl/winograd_tile_sequencer.sv
// Walks a tiles_x by tiles_y grid in raster order, reads each 4x4 tile from the
// tile buffer, passes it through the external 2-stage input transform and
// queues the transformed tile with its grid coordinates for a ready/valid sink.
// The transform cannot stall, so a read is issued only while the tiles already
// queued plus the tiles still inside the read/transform pipe leave a FIFO slot.
//   clk, rstn               clock, asynchronous active-low reset
//   start                   frame start pulse, honoured only when idle
//   cfg_tiles_x/_y          grid size, captured on an accepted start
//   busy, done              frame active / one-cycle completion pulse
//   rd_en, rd_addr, rd_data tile-buffer read port (data one cycle after rd_en)
//   xf_data_in/_out         transform input (= rd_data) and output (3 cycles after rd_en)
//   out_valid/ready/data    transformed tile stream
//   out_tx, out_ty          grid coordinates of out_data
module winograd_tile_sequencer
  import winograd_pkg::*;
#(
  parameter int unsigned W      = 8,
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned TC_W   = 5,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       start,
  input  logic [TC_W-1:0]            cfg_tiles_x,
  input  logic [TC_W-1:0]            cfg_tiles_y,
  output logic                       busy,
  output logic                       done,
  output logic                       rd_en,
  output logic [ADDR_W-1:0]          rd_addr,
  input  logic [W*TILE_ELEMS-1:0]    rd_data,
  output logic [W*TILE_ELEMS-1:0]    xf_data_in,
  input  logic [W*TILE_ELEMS-1:0]    xf_data_out,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [W*TILE_ELEMS-1:0]    out_data,
  output logic [TC_W-1:0]            out_tx,
  output logic [TC_W-1:0]            out_ty
);

  localparam int unsigned DATA_W  = W * TILE_ELEMS;
  localparam int unsigned ENTRY_W = DATA_W + 2 * TC_W;
  localparam int unsigned CNT_W   = $clog2(DEPTH + 1);
  localparam logic [TC_W-1:0] TC_ONE = TC_W'(1);

  state_e state_q, state_d;

  logic [TC_W-1:0]   tiles_x_q, tiles_y_q;
  logic [TC_W-1:0]   tx_q, tx_d, ty_q, ty_d;
  logic [ADDR_W-1:0] base_q, base_d;

  // Valid/coordinate pipe aligned with rd_data, B_Td and xf_data_out.
  logic [2:0]        stg_valid_q;
  logic [2*TC_W-1:0] stg_coord_q [3];

  logic              accept_start, cfg_zero, credit, issue;
  logic              tx_wrap, last_issue, drain_done;
  logic [1:0]        inflight;
  logic [CNT_W:0]    occupancy;

  logic              fifo_push, fifo_pop, fifo_empty, fifo_full;
  logic [CNT_W-1:0]  fifo_count;
  logic [ENTRY_W-1:0] fifo_wdata, fifo_rdata;

  assign accept_start = (state_q == StIdle) && start;
  assign cfg_zero     = (cfg_tiles_x == '0) || (cfg_tiles_y == '0);

  assign inflight  = 2'(stg_valid_q[0]) + 2'(stg_valid_q[1]) + 2'(stg_valid_q[2]);
  assign occupancy = (CNT_W + 1)'(fifo_count) + (CNT_W + 1)'(inflight);
  // Credit uses registered state only, so rd_en has no combinational path from out_ready.
  assign credit    = occupancy < (CNT_W + 1)'(DEPTH);

  assign issue      = rd_en;
  assign tx_wrap    = (tx_q == tiles_x_q - TC_ONE);
  assign last_issue = issue && tx_wrap && (ty_q == tiles_y_q - TC_ONE);

  // The last tile leaves once the pipe is empty and the FIFO is empty after this cycle's pop.
  assign drain_done = (inflight == 2'd0) &&
                      ((fifo_count == '0) || ((fifo_count == CNT_W'(1)) && fifo_pop));

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (start) state_d = cfg_zero ? StDone : StRun;
      StRun:   if (last_issue) state_d = StDrain;
      StDrain: if (drain_done) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    busy  = 1'b1;
    done  = 1'b0;
    rd_en = 1'b0;
    case (state_q)
      StIdle:  busy  = 1'b0;
      StRun:   rd_en = credit;
      StDone:  done  = 1'b1;
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Grid walk
  // ---------------------------------------------------------------------------
  always_comb begin
    tx_d   = tx_q;
    ty_d   = ty_q;
    base_d = base_q;
    if (accept_start) begin
      tx_d   = '0;
      ty_d   = '0;
      base_d = '0;
    end else if (issue) begin
      if (tx_wrap) begin
        tx_d   = '0;
        ty_d   = ty_q + TC_ONE;
        base_d = base_q + ADDR_W'(tiles_x_q);
      end else begin
        tx_d = tx_q + TC_ONE;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tiles_x_q <= '0;
      tiles_y_q <= '0;
      tx_q      <= '0;
      ty_q      <= '0;
      base_q    <= '0;
    end else begin
      if (accept_start) begin
        tiles_x_q <= cfg_tiles_x;
        tiles_y_q <= cfg_tiles_y;
      end
      tx_q   <= tx_d;
      ty_q   <= ty_d;
      base_q <= base_d;
    end
  end

  assign rd_addr    = base_q + ADDR_W'(tx_q);
  assign xf_data_in = rd_data;

  // ---------------------------------------------------------------------------
  // In-flight tracking
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stg_valid_q <= '0;
      for (int i = 0; i < 3; i++) stg_coord_q[i] <= '0;
    end else begin
      stg_valid_q    <= {stg_valid_q[1:0], issue};
      stg_coord_q[0] <= {tx_q, ty_q};
      stg_coord_q[1] <= stg_coord_q[0];
      stg_coord_q[2] <= stg_coord_q[1];
    end
  end

  // ---------------------------------------------------------------------------
  // Output queue
  // ---------------------------------------------------------------------------
  assign fifo_push  = stg_valid_q[2];
  assign fifo_wdata = {xf_data_out, stg_coord_q[2]};
  assign fifo_pop   = out_valid && out_ready;

  tile_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rstn      (rstn),
    .push      (fifo_push),
    .push_data (fifo_wdata),
    .pop       (fifo_pop),
    .pop_data  (fifo_rdata),
    .empty     (fifo_empty),
    .full      (fifo_full),
    .count     (fifo_count)
  );

  assign out_valid = !fifo_empty;
  // Gate the payload so it reads as zero while nothing is queued (storage is not reset).
  assign out_data  = fifo_empty ? '0 : fifo_rdata[ENTRY_W-1 -: DATA_W];
  assign out_tx    = fifo_empty ? '0 : fifo_rdata[2*TC_W-1 -: TC_W];
  assign out_ty    = fifo_empty ? '0 : fifo_rdata[TC_W-1:0];

  assert property (@(posedge clk) disable iff (!rstn) !(fifo_push && fifo_full && !fifo_pop));
  assert property (@(posedge clk) disable iff (!rstn) occupancy <= (CNT_W + 1)'(DEPTH));

endmodule

// File: tb/tb_winograd_tile_sequencer.sv
// Scoreboard bench: each frame's expected tiles are queued before start, a
// negedge monitor pops and compares on every accepted output.
module tb_winograd_tile_sequencer;

  localparam int unsigned W      = 8;
  localparam int unsigned ADDR_W = 10;
  localparam int unsigned TC_W   = 5;
  localparam int unsigned DEPTH  = 4;
  localparam int unsigned TB     = W * 16;

  logic              clk = 1'b0;
  logic              rstn = 1'b0;
  logic              start = 1'b0;
  logic [TC_W-1:0]   cfg_tiles_x = '0;
  logic [TC_W-1:0]   cfg_tiles_y = '0;
  logic              busy, done, rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [TB-1:0]     rd_data = '0;
  logic [TB-1:0]     xf_data_in;
  logic [TB-1:0]     xf_data_out = '0;
  logic [TB-1:0]     btd_q = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [TB-1:0]     out_data;
  logic [TC_W-1:0]   out_tx, out_ty;

  typedef struct {
    logic [TB-1:0]   data;
    logic [TC_W-1:0] tx;
    logic [TC_W-1:0] ty;
  } exp_t;

  exp_t sb_q[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int s_cyc = 0;
  int tile_mode = 0;  // 0: all-ones tiles, 1: byte0 = address + 1, rest zero
  int rd_cnt = 0, acc_cnt = 0, vld_cnt = 0, max_occ = 0;

  winograd_tile_sequencer #(
    .W      (W),
    .ADDR_W (ADDR_W),
    .TC_W   (TC_W),
    .DEPTH  (DEPTH)
  ) dut (
    .clk         (clk),
    .rstn        (rstn),
    .start       (start),
    .cfg_tiles_x (cfg_tiles_x),
    .cfg_tiles_y (cfg_tiles_y),
    .busy        (busy),
    .done        (done),
    .rd_en       (rd_en),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .xf_data_in  (xf_data_in),
    .xf_data_out (xf_data_out),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_tx      (out_tx),
    .out_ty      (out_ty)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [TB-1:0] gen_tile(input logic [ADDR_W-1:0] a);
    logic [TB-1:0] t;
    if (tile_mode == 0) begin
      t = {16{8'h01}};
    end else begin
      t = '0;
      t[7:0] = a[7:0] + 8'd1;
    end
    return t;
  endfunction

  // B^T * d: combines rows within each column.
  function automatic logic [TB-1:0] col_pass(input logic [TB-1:0] d);
    logic [TB-1:0] r;
    logic [7:0] e0, e1, e2, e3;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      e0 = d[(0 * 4 + c) * 8 +: 8];
      e1 = d[(1 * 4 + c) * 8 +: 8];
      e2 = d[(2 * 4 + c) * 8 +: 8];
      e3 = d[(3 * 4 + c) * 8 +: 8];
      r[(0 * 4 + c) * 8 +: 8] = e0 - e2;
      r[(1 * 4 + c) * 8 +: 8] = e1 + e2;
      r[(2 * 4 + c) * 8 +: 8] = e2 - e1;
      r[(3 * 4 + c) * 8 +: 8] = e1 - e3;
    end
    return r;
  endfunction

  // X * B: combines columns within each row.
  function automatic logic [TB-1:0] row_pass(input logic [TB-1:0] x);
    logic [TB-1:0] r;
    logic [7:0] e0, e1, e2, e3;
    r = '0;
    for (int rr = 0; rr < 4; rr++) begin
      e0 = x[(rr * 4 + 0) * 8 +: 8];
      e1 = x[(rr * 4 + 1) * 8 +: 8];
      e2 = x[(rr * 4 + 2) * 8 +: 8];
      e3 = x[(rr * 4 + 3) * 8 +: 8];
      r[(rr * 4 + 0) * 8 +: 8] = e0 - e2;
      r[(rr * 4 + 1) * 8 +: 8] = e1 + e2;
      r[(rr * 4 + 2) * 8 +: 8] = e2 - e1;
      r[(rr * 4 + 3) * 8 +: 8] = e1 - e3;
    end
    return r;
  endfunction

  // Tile buffer (1-cycle read) and the 2-stage transform outside the DUT.
  always @(posedge clk) begin
    if (rd_en) rd_data <= gen_tile(rd_addr);
    btd_q       <= col_pass(xf_data_in);
    xf_data_out <= row_pass(btd_q);
  end

  task automatic check(input string name, input logic [TB-1:0] act, input logic [TB-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Hand-derived results: all-ones transforms to 4 at element (1,1) only;
  // a tile holding k at element (0,0) only transforms to itself.
  task automatic push_frame(input int nx, input int ny);
    exp_t e;
    for (int y = 0; y < ny; y++) begin
      for (int x = 0; x < nx; x++) begin
        e.data = '0;
        if (tile_mode == 0) e.data[47:40] = 8'h04;
        else e.data[7:0] = 8'(y * nx + x + 1);
        e.tx = TC_W'(x);
        e.ty = TC_W'(y);
        sb_q.push_back(e);
      end
    end
  endtask

  task automatic start_frame(input int nx, input int ny);
    @(posedge clk);
    #1;
    cfg_tiles_x = TC_W'(nx);
    cfg_tiles_y = TC_W'(ny);
    start = 1'b1;
    s_cyc = cyc;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input bit rnd, output int at);
    at = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done) begin
        at = cyc;
        break;
      end
      if (rnd) begin
        @(posedge clk);
        #1;
        out_ready = ($urandom_range(0, 1) == 1);
      end
    end
    if (at < 0) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got no done within %0d cycles, expected one pulse", budget);
    end
  endtask

  // Monitor: counts issues/accepts, tracks outstanding tiles, scores outputs.
  initial begin
    exp_t e;
    int occ;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        rd_cnt = 0;
        acc_cnt = 0;
        vld_cnt = 0;
        max_occ = 0;
      end else begin
        if (start && !busy) max_occ = 0;
        occ = (rd_cnt - acc_cnt) + (rd_en ? 1 : 0);
        if (occ > max_occ) max_occ = occ;
        if (rd_en) rd_cnt++;
        if (out_valid) vld_cnt++;
        if (out_valid && out_ready) begin
          acc_cnt++;
          if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_output: got tile (%0d,%0d) expected none", out_tx, out_ty);
          end else begin
            e = sb_q.pop_front();
            check("out_data", out_data, e.data);
            check("out_coord", {out_tx, out_ty}, {e.tx, e.ty});
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no summary by time limit, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int at, r0, a0, v0, rel;

    // Reset state
    #12;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_rd_en", rd_en, 0);
    check("rst_rd_addr", rd_addr, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_coord", {out_tx, out_ty}, 0);
    @(negedge clk);
    rstn = 1'b1;
    repeat (2) @(negedge clk);

    // 2x2 all-ones, ready high
    tile_mode = 0;
    out_ready = 1'b1;
    push_frame(2, 2);
    start_frame(2, 2);
    @(negedge clk);
    check("busy_after_start", busy, 1);
    for (int k = 0; k < 4; k++) begin
      if (k != 0) @(negedge clk);
      check("t1_rd_en", rd_en, 1);
      check("t1_rd_addr", rd_addr, k);
    end
    wait_done(60, 1'b0, at);
    check("t1_done_latency", at - s_cyc, 9);
    @(negedge clk);
    check("t1_done_pulse", {busy, done}, 0);
    check("t1_sb_empty", sb_q.size(), 0);

    // 3x1 with ready held low: all three issue, nothing lost
    tile_mode = 1;
    out_ready = 1'b0;
    r0 = rd_cnt;
    a0 = acc_cnt;
    push_frame(3, 1);
    start_frame(3, 1);
    repeat (20) @(negedge clk);
    check("t2_issues", rd_cnt - r0, 3);
    check("t2_no_accept", acc_cnt - a0, 0);
    check("t2_out_valid", out_valid, 1);
    check("t2_busy_stalled", {busy, done}, 2'b10);
    check("t2_max_occ", max_occ, 3);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    rel = cyc;
    wait_done(60, 1'b0, at);
    check("t2_done_after_release", at - rel, 3);
    check("t2_sb_empty", sb_q.size(), 0);

    // 4x4 random ready, with a start pulse while busy that must be ignored
    r0 = rd_cnt;
    a0 = acc_cnt;
    push_frame(4, 4);
    start_frame(4, 4);
    @(posedge clk);
    #1;
    cfg_tiles_x = 5'd1;
    cfg_tiles_y = 5'd1;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(600, 1'b1, at);
    out_ready = 1'b1;
    check("t3_issues", rd_cnt - r0, 16);
    check("t3_accepts", acc_cnt - a0, 16);
    check("t3_occ_bound", max_occ <= DEPTH, 1);
    check("t3_sb_empty", sb_q.size(), 0);
    repeat (4) @(negedge clk);
    check("t3_no_extra_frame", busy, 0);

    // Zero-tile frame
    r0 = rd_cnt;
    a0 = acc_cnt;
    v0 = vld_cnt;
    start_frame(0, 3);
    @(negedge clk);
    check("t4_done", done, 1);
    check("t4_rd_en", rd_en, 0);
    @(negedge clk);
    check("t4_idle", {busy, done}, 0);
    repeat (6) @(negedge clk);
    check("t4_no_issue", rd_cnt - r0, 0);
    check("t4_no_valid", vld_cnt - v0, 0);

    // Reset with two tiles in flight, then a 1x1 frame
    tile_mode = 1;
    out_ready = 1'b1;
    start_frame(3, 3);
    @(posedge clk);
    @(posedge clk);
    #1;
    rstn = 1'b0;
    #1;
    check("t5_busy", busy, 0);
    check("t5_done", done, 0);
    check("t5_rd_en", rd_en, 0);
    check("t5_rd_addr", rd_addr, 0);
    check("t5_out_valid", out_valid, 0);
    check("t5_out_data", out_data, 0);
    check("t5_out_coord", {out_tx, out_ty}, 0);
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    r0 = rd_cnt;
    a0 = acc_cnt;
    push_frame(1, 1);
    start_frame(1, 1);
    wait_done(60, 1'b0, at);
    check("t5_done_latency", at - s_cyc, 6);
    check("t5_one_issue", rd_cnt - r0, 1);
    check("t5_one_tile", acc_cnt - a0, 1);
    check("t5_sb_empty", sb_q.size(), 0);
    repeat (3) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
